// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle of the direct-mapped data cache.
// The slave modport is the cache controller; master is the pipeline/memory side.
interface dcache_ctrl_if #(
  parameter int MEM_W = 256
);
  logic             cpu_req_i;
  logic             cpu_write_i;
  logic [31:0]      cpu_addr_i;
  logic [31:0]      cpu_data_i;
  logic [31:0]      cpu_data_o;
  logic             cpu_stall_o;
  logic             mem_enable_o;
  logic             mem_write_o;
  logic [31:0]      mem_addr_o;
  logic [MEM_W-1:0] mem_data_o;
  logic [MEM_W-1:0] mem_data_i;
  logic             mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller with
// internal tag/data storage and a line-wide off-chip memory handshake.
module dcache_ctrl #(
  parameter int NLINES = 16,
  parameter int MEM_W  = 256
) (
  input logic          clk_i,
  input logic          rst_i,
  dcache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NLINES);
  localparam int TAG_W = 23;
  localparam int OFF_W = $clog2(MEM_W);

  typedef enum logic [1:0] {IDLE, WB, ALLOC, REFILL} state_t;

  state_t              state_q, state_d;
  logic [NLINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [NLINES];
  logic [MEM_W-1:0]    data_q [NLINES];
  logic [MEM_W-1:0]    fill_q;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    idx;
  logic [OFF_W-1:0]    word_off;
  logic [MEM_W-1:0]    cur_line;
  logic                hit, store_hit;
  wire                 unused_byte_bits = ^bus.cpu_addr_i[1:0];

  assign req_tag   = bus.cpu_addr_i[31:9];
  assign idx       = bus.cpu_addr_i[8:5];
  assign word_off  = {bus.cpu_addr_i[4:2], 5'b0};
  assign cur_line  = data_q[idx];
  assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
  assign store_hit = (state_q == IDLE) && bus.cpu_req_i && bus.cpu_write_i && hit;

  // Control state and per-line status bits; reset invalidates every line.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ALLOC && bus.mem_ack_i) begin
        fill_q <= bus.mem_data_i;
      end
      if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
      if (state_q == REFILL) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays are not reset; valid bits alone guarantee misses.
  always_ff @(posedge clk_i) begin
    if (state_q == REFILL) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= fill_q;
    end else if (store_hit) begin
      data_q[idx][word_off +: 32] <= bus.cpu_data_i;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.cpu_stall_o  = 1'b1;
    bus.cpu_data_o   = '0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        bus.cpu_stall_o = bus.cpu_req_i && !hit;
        if (bus.cpu_req_i && hit) begin
          bus.cpu_data_o = cur_line[word_off +: 32];
        end
        if (bus.cpu_req_i && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WB : ALLOC;
        end
      end
      WB: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {tag_q[idx], idx, 5'b0};
        bus.mem_data_o   = cur_line;
        if (bus.mem_ack_i) begin
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {bus.cpu_addr_i[31:5], 5'b0};
        if (bus.mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed scoreboard bench for dcache_ctrl: miss/refill, store hit, dirty
// write-back with slow memory, reset mid-transaction and stray acks.
module tb_dcache_ctrl;
  logic clk_i;
  logic rst_i;

  dcache_ctrl_if bus ();

  dcache_ctrl #(.NLINES(16), .MEM_W(256)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  typedef struct {
    string        tag;
    logic [255:0] val;
  } exp_t;

  exp_t         sb_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [255:0] line_a, line_b, exp_wb;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [255:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input logic [255:0] observed);
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_empty observed=%h required=queued_entry", observed);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    assert (observed === e.val)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.val);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_req_i   = req;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = addr;
    bus.cpu_data_i  = data;
  endtask

  task automatic mem_ack_pulse(input logic [255:0] line);
    bus.mem_data_i = line;
    bus.mem_ack_i  = 1'b1;
    tick();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      line_a[k*32 +: 32] = 32'hA000_0000 | k;
      line_b[k*32 +: 32] = 32'hB000_0000 | k;
    end
    line_a[63:32] = 32'hDEAD_BEEF;
    line_b[95:64] = 32'hCAFE_F00D;
    exp_wb = line_a;
    exp_wb[95:64] = 32'h1234_5678;

    rst_i = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    #1 rst_i = 1'b0;
    expect_val("rst_stall", 256'd0);
    expect_val("rst_mem_enable", 256'd0);
    expect_val("rst_mem_write", 256'd0);
    expect_val("rst_mem_addr", 256'd0);
    expect_val("rst_mem_data", 256'd0);
    expect_val("rst_cpu_data", 256'd0);
    #2;
    check_output(256'(bus.cpu_stall_o));
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.mem_write_o));
    check_output(256'(bus.mem_addr_o));
    check_output(bus.mem_data_o);
    check_output(256'(bus.cpu_data_o));
    @(negedge clk_i) rst_i = 1'b1;
    tick();

    $display("[TB] load miss 0x104, clean allocate");
    apply_stimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0);
    expect_val("miss_stall", 256'd1);
    expect_val("miss_idle_enable", 256'd0);
    #1;
    check_output(256'(bus.cpu_stall_o));
    check_output(256'(bus.mem_enable_o));
    tick();
    expect_val("alloc_enable", 256'd1);
    expect_val("alloc_write", 256'd0);
    expect_val("alloc_addr", 256'h100);
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.mem_write_o));
    check_output(256'(bus.mem_addr_o));
    tick();
    tick();
    mem_ack_pulse(line_a);
    expect_val("refill_stall", 256'd1);
    expect_val("refill_enable", 256'd0);
    check_output(256'(bus.cpu_stall_o));
    check_output(256'(bus.mem_enable_o));
    tick();
    expect_val("hit_stall", 256'd0);
    expect_val("hit_data_104", 256'h DEAD_BEEF);
    check_output(256'(bus.cpu_stall_o));
    check_output(256'(bus.cpu_data_o));

    $display("[TB] store hit 0x108 then load back");
    apply_stimulus(1'b1, 1'b1, 32'h0000_0108, 32'h1234_5678);
    expect_val("store_stall", 256'd0);
    #1;
    check_output(256'(bus.cpu_stall_o));
    tick();
    apply_stimulus(1'b1, 1'b0, 32'h0000_0108, 32'h0);
    expect_val("reload_stall", 256'd0);
    expect_val("reload_data_108", 256'h1234_5678);
    #1;
    check_output(256'(bus.cpu_stall_o));
    check_output(256'(bus.cpu_data_o));
    tick();

    $display("[TB] conflict miss 0x308 with dirty victim, slow memory");
    apply_stimulus(1'b1, 1'b0, 32'h0000_0308, 32'h0);
    expect_val("conflict_stall", 256'd1);
    #1;
    check_output(256'(bus.cpu_stall_o));
    tick();
    expect_val("wb_enable", 256'd1);
    expect_val("wb_write", 256'd1);
    expect_val("wb_addr", 256'h100);
    expect_val("wb_line", exp_wb);
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.mem_write_o));
    check_output(256'(bus.mem_addr_o));
    check_output(bus.mem_data_o);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_val("wb_hold_enable", 256'd1);
      expect_val("wb_hold_addr", 256'h100);
      expect_val("wb_hold_stall", 256'd1);
      check_output(256'(bus.mem_enable_o));
      check_output(256'(bus.mem_addr_o));
      check_output(256'(bus.cpu_stall_o));
    end
    mem_ack_pulse('0);
    expect_val("alloc2_enable", 256'd1);
    expect_val("alloc2_write", 256'd0);
    expect_val("alloc2_addr", 256'h300);
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.mem_write_o));
    check_output(256'(bus.mem_addr_o));
    mem_ack_pulse(line_b);
    tick();
    expect_val("hit2_stall", 256'd0);
    expect_val("hit2_data_308", 256'h CAFE_F00D);
    check_output(256'(bus.cpu_stall_o));
    check_output(256'(bus.cpu_data_o));

    $display("[TB] spurious ack while idle");
    apply_stimulus(1'b0, 1'b0, 32'h0000_0308, 32'h0);
    bus.mem_data_i = '1;
    bus.mem_ack_i  = 1'b1;
    tick();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    expect_val("stray_enable", 256'd0);
    expect_val("stray_stall", 256'd0);
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.cpu_stall_o));
    apply_stimulus(1'b1, 1'b0, 32'h0000_0308, 32'h0);
    expect_val("after_stray_stall", 256'd0);
    expect_val("after_stray_data", 256'h CAFE_F00D);
    #1;
    check_output(256'(bus.cpu_stall_o));
    check_output(256'(bus.cpu_data_o));
    tick();

    $display("[TB] reset pulsed during allocate");
    apply_stimulus(1'b1, 1'b0, 32'h0000_0508, 32'h0);
    tick();
    expect_val("alloc3_enable", 256'd1);
    expect_val("alloc3_addr", 256'h500);
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.mem_addr_o));
    #2 rst_i = 1'b0;
    expect_val("midrst_enable", 256'd0);
    expect_val("midrst_addr", 256'd0);
    expect_val("midrst_cpu_data", 256'd0);
    #1;
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.mem_addr_o));
    check_output(256'(bus.cpu_data_o));
    @(negedge clk_i);
    rst_i = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_data_i = line_b;
    bus.mem_ack_i  = 1'b1;
    tick();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    expect_val("post_rst_stray_enable", 256'd0);
    expect_val("post_rst_stray_stall", 256'd0);
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.cpu_stall_o));
    apply_stimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    expect_val("post_rst_miss_stall", 256'd1);
    #1;
    check_output(256'(bus.cpu_stall_o));
    tick();
    expect_val("post_rst_alloc_enable", 256'd1);
    expect_val("post_rst_alloc_write", 256'd0);
    expect_val("post_rst_alloc_addr", 256'h300);
    check_output(256'(bus.mem_enable_o));
    check_output(256'(bus.mem_write_o));
    check_output(256'(bus.mem_addr_o));
    mem_ack_pulse(line_b);
    tick();
    expect_val("post_rst_hit_stall", 256'd0);
    expect_val("post_rst_hit_data", 256'h B000_0000);
    check_output(256'(bus.cpu_stall_o));
    check_output(256'(bus.cpu_data_o));

    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
